// File: rtl/alu_mult_seq_pkg.sv
// rtl/alu_mult_seq_pkg.sv - shared state encoding and ALU opcode constants for the multiply sequencer
package alu_mult_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ABS_A  = 3'd1,
    ST_ABS_B  = 3'd2,
    ST_MUL    = 3'd3,
    ST_NEG_LO = 3'd4,
    ST_NEG_HI = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b100;

endpackage

// File: rtl/alu_mult_seq_ctrl_fsm.sv
// rtl/alu_mult_seq_ctrl_fsm.sv - sequencing FSM: state register, iteration counter, next-state logic
module alu_mult_seq_ctrl_fsm
  import alu_mult_seq_pkg::*;
#(
  parameter int N     = 16,
  parameter int CNT_W = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   start_i,
  input  logic   sgn_i,
  output state_t state_o,
  output logic   fin_o
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sgn_q;
  logic             last_iter;

  assign last_iter = (cnt_q == CNT_W'(N-1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            sgn_q   <= sgn_i;
            cnt_q   <= '0;
            state_q <= sgn_i ? ST_ABS_A : ST_MUL;
          end
        end
        ST_ABS_A:  state_q <= ST_ABS_B;
        ST_ABS_B:  state_q <= ST_MUL;
        ST_MUL: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) state_q <= sgn_q ? ST_NEG_LO : ST_DONE;
        end
        ST_NEG_LO: state_q <= ST_NEG_HI;
        ST_NEG_HI: state_q <= ST_DONE;
        ST_DONE:   state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // High on the cycle whose edge moves the FSM into DONE, so the product can be captured then.
  assign fin_o   = ((state_q == ST_MUL) && last_iter && !sgn_q) || (state_q == ST_NEG_HI);
  assign state_o = state_q;

endmodule

// File: rtl/alu_mult_seq.sv
// rtl/alu_mult_seq.sv - multi-cycle 16x16 shift-add multiplier driving the shared external ALU
module alu_mult_seq
  import alu_mult_seq_pkg::*;
#(
  parameter int N     = 16,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sgn,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] prod,
  output logic [N-1:0]   alu_A,
  output logic [N-1:0]   alu_B,
  output logic           alu_Cin,
  output logic [2:0]     alu_Op,
  output logic           alu_invA,
  output logic           alu_invB,
  output logic           alu_sign,
  input  logic [N-1:0]   alu_Out,
  input  logic           alu_Carry
);

  state_t           state;
  logic             fin;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]     hi_q, hi_d;
  logic [N-1:0]     lo_q, lo_d;
  logic             neg_q, neg_d;
  logic             nc_q, nc_d;
  logic [2*N-1:0]   prod_q, prod_d;

  alu_mult_seq_ctrl_fsm #(.N(N), .CNT_W(CNT_W)) u_ctrl (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .sgn_i   (sgn),
    .state_o (state),
    .fin_o   (fin)
  );

  // Every ALU use is an add; negation is 0 + ~x + cin.
  always_comb begin
    alu_A    = '0;
    alu_B    = '0;
    alu_Cin  = 1'b0;
    alu_invB = 1'b0;
    unique case (state)
      ST_ABS_A:  begin alu_B = mcand_q; alu_invB = 1'b1; alu_Cin = 1'b1; end
      ST_ABS_B:  begin alu_B = lo_q;    alu_invB = 1'b1; alu_Cin = 1'b1; end
      ST_MUL:    begin alu_A = hi_q;    alu_B = mcand_q; end
      ST_NEG_LO: begin alu_B = lo_q;    alu_invB = 1'b1; alu_Cin = 1'b1; end
      ST_NEG_HI: begin alu_B = hi_q;    alu_invB = 1'b1; alu_Cin = nc_q; end
      default:   ;
    endcase
  end

  assign alu_Op   = OP_ADD;
  assign alu_invA = 1'b0;
  assign alu_sign = 1'b0;

  always_comb begin
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    nc_d    = nc_q;
    prod_d  = prod_q;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          neg_d   = sgn & (a[N-1] ^ b[N-1]);
        end
      end
      ST_ABS_A:  if (mcand_q[N-1]) mcand_d = alu_Out;
      ST_ABS_B:  if (lo_q[N-1])    lo_d    = alu_Out;
      ST_MUL: begin
        if (lo_q[0]) {hi_d, lo_d} = {alu_Carry, alu_Out, lo_q[N-1:1]};
        else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[N-1:1]};
      end
      ST_NEG_LO: if (neg_q) begin lo_d = alu_Out; nc_d = alu_Carry; end
      ST_NEG_HI: if (neg_q) hi_d = alu_Out;
      default:   ;
    endcase
    if (fin) prod_d = {hi_d, lo_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      nc_q    <= 1'b0;
      prod_q  <= '0;
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      nc_q    <= nc_d;
      prod_q  <= prod_d;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign prod = prod_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// tb/tb_alu_mult_seq.sv - self-checking bench for alu_mult_seq with a behavioural ALU and product model
module tb_alu_mult_seq;

  logic        clk = 1'b0;
  logic        rst, start, sgn;
  logic [15:0] a, b;
  logic        busy, done;
  logic [31:0] prod;
  logic [15:0] alu_A, alu_B, alu_Out;
  logic        alu_Cin, alu_invA, alu_invB, alu_sign, alu_Carry;
  logic [2:0]  alu_Op;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // External ALU, add function only
  assign {alu_Carry, alu_Out} = {1'b0, (alu_invA ? ~alu_A : alu_A)}
                              + {1'b0, (alu_invB ? ~alu_B : alu_B)}
                              + {16'b0, alu_Cin};

  alu_mult_seq dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .prod(prod),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Cin(alu_Cin), .alu_Op(alu_Op),
    .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_sign(alu_sign),
    .alu_Out(alu_Out), .alu_Carry(alu_Carry)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic s);
    int          sx, sy;
    int unsigned ux, uy;
    if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      return 32'(sx * sy);
    end
    ux = x;
    uy = y;
    return ux * uy;
  endfunction

  // inj >= 1: pulse start with junk operands in that cycle after accept; inj_done: pulse in DONE cycle
  task automatic do_op(input logic [15:0] aa, input logic [15:0] bb, input logic s,
                       input int inj, input bit inj_done, input string tag);
    logic [31:0] exp;
    int          cyc;
    exp = ref_mul(aa, bb, s);
    @(negedge clk);
    a = aa; b = bb; sgn = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk({tag, " busy_after_accept"}, {31'b0, busy}, 32'd1);
    while (done !== 1'b1 && cyc < 40) begin
      if (cyc == inj) begin
        start = 1'b1; a = 16'($urandom); b = 16'($urandom); sgn = ~s;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), s ? 32'd21 : 32'd17);
    chk({tag, " prod"}, prod, exp);
    if (inj_done) begin
      start = 1'b1; a = 16'($urandom); b = 16'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, " done_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, " busy_low"}, {31'b0, busy}, 32'd0);
    chk({tag, " prod_held"}, prod, exp);
    if (inj_done) begin
      @(negedge clk);
      chk({tag, " done_start_ignored"}, {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset prod", prod, 32'd0);
    chk("reset alu_A", {16'b0, alu_A}, 32'd0);
    chk("reset alu_B", {16'b0, alu_B}, 32'd0);
    chk("reset alu_Cin/invB", {30'b0, alu_Cin, alu_invB}, 32'd0);
    chk("alu_Op", {29'b0, alu_Op}, 32'd4);
    chk("alu_invA/sign", {30'b0, alu_invA, alu_sign}, 32'd0);

    do_op(16'h0003, 16'h0005, 1'b0, -1, 1'b0, "u3x5");
    do_op(16'hFFFF, 16'hFFFF, 1'b0, -1, 1'b0, "uFFFFxFFFF");
    do_op(16'hFFFD, 16'h0005, 1'b1, -1, 1'b0, "s-3x5");
    do_op(16'hFFFD, 16'hFFFB, 1'b1, -1, 1'b0, "s-3x-5");
    do_op(16'h8000, 16'h8000, 1'b1, -1, 1'b0, "s8000x8000");
    do_op(16'h8000, 16'h0001, 1'b1, -1, 1'b0, "s8000x1");
    do_op(16'h0000, 16'h1234, 1'b1, -1, 1'b0, "s0xN");
    do_op(16'h1234, 16'h0000, 1'b0, -1, 1'b0, "uNx0");
    do_op(16'h00AB, 16'h0CDE, 1'b0, 9, 1'b1, "ignore_mid_done_u");
    do_op(16'hF00D, 16'h0123, 1'b1, 12, 1'b1, "ignore_mid_done_s");

    // Reset during MUL discards the operation
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; sgn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst done", {31'b0, done}, 32'd0);
    chk("midrst prod", prod, 32'd0);
    chk("midrst alu_A", {16'b0, alu_A}, 32'd0);
    do_op(16'h0007, 16'h0009, 1'b0, -1, 1'b0, "after_rst7x9");

    for (int i = 0; i < 24; i++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), -1, 1'b0, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
